flash_writer: RTL and testbench
===============================

Name: flash_writer

Overview:
- Bus-mastering SPI flash programmer: the write-direction counterpart of the boot loader, which reads flash into RAM.
- On a start pulse it takes the 6502 bus, reads a block of bytes from RAM, and programs them into the SPI flash.
- Each page uses the sequence WREN (0x06), Page Program (0x02), then Read Status (0x05) polled until WIP clears.
- Sits beside boot inside bifrost; the top level muxes addr/rw/flash pins from whichever block is active.

Parameters:
- RAM_AW, 19, RAM/bus address width.
- PAGE_BYTES, 256, flash page size; power of two.
- POLL_LIMIT, 65535, maximum status reads per page before error.

Ports:
- clock  input  1  system clock (bifrost clockout domain).
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- ram_base  input  RAM_AW  first RAM byte address; latched on start.
- flash_base  input  24  first flash byte address; latched on start.
- length  input  16  byte count; 0 = no-op.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse at completion or error.
- error  output  1  sticky until next accepted start; set on poll timeout.
- bus_req  output  1  high while the block owns the bus.
- address  output  RAM_AW  RAM read address.
- rw  output  1  always 1 (read) while bus_req.
- data  input  8  RAM read data.
- flash_cs_n  output  1  flash chip select.
- flash_sck  output  1  SPI clock.
- flash_si  output  1  MOSI.
- flash_so  input  1  MISO.

Behaviour:
- Reset values: busy=0, done=0, error=0, bus_req=0, address=0, rw=1, flash_cs_n=1, flash_sck=0, flash_si=0. Reset takes effect at the next edge from any state, including mid-transfer: CS is released and the bus dropped. A partially programmed page is not recovered.
- SPI is mode 0, MSB first, two clocks per bit:
  - phase 0: sck=0, si updated;
  - phase 1: sck=1, so sampled at the end of phase 1.
  - One byte = 16 clocks.
- flash_cs_n is low for the whole command. It is high for at least 2 clocks between commands.
- States and transitions:
  - IDLE: on start, latch ram_base, flash_base, length; clear error.
    - If length=0: pulse done next cycle, busy stays 0, no bus or flash activity.
    - Otherwise go to WREN with busy=1, bus_req=1.
  - WREN: shift 0x06, raise CS, 2-clock gap -> PROG_HDR.
  - PROG_HDR: shift 0x02, then flash address [23:16], [15:8], [7:0] -> FETCH.
  - FETCH: drive address=current RAM pointer, rw=1. data is sampled 2 clocks after address is driven (one wait cycle) -> SHIFT.
  - SHIFT: shift the byte out, then increment the RAM pointer and flash address (24-bit wrap 0xFFFFFF->0), decrement remaining.
    - If remaining=0 or flash address[log2 PAGE_BYTES-1:0] is now 0: raise CS, gap -> POLL.
    - Otherwise -> FETCH. CS stays low across fetches and sck is held at 0.
  - POLL: shift 0x05, then read status bytes continuously with CS held low. si=0 during reads.
    - Status bit0=0: raise CS. If remaining=0 -> DONE, else gap -> WREN.
    - POLL_LIMIT status bytes read with WIP still 1: raise CS, set error -> DONE.
  - DONE: done=1 for one cycle, busy=0, bus_req=0 -> IDLE.
- A page crossing splits the transfer into independent WREN/program/poll sequences. The first page may be partial.
- start while busy is ignored. Inputs are not re-sampled during an operation.
- RAM pointer wraps modulo 2^RAM_AW.

Test Plan:
- length=4, ram_base=0x01000 holding DE AD BE EF, flash_base=0x000010, status model returns 0x00 → required SPI traffic:
  - CS frame 06;
  - CS frame 02 00 00 10 DE AD BE EF;
  - CS frame 05 + one status byte;
  - done pulse, error=0; RAM reads at 0x01000..0x01003.
- flash_base=0x0000FE, length=4 → two program frames: 02 00 00 FE + 2 bytes, then 02 00 01 00 + 2 bytes. Each frame is preceded by 06 and followed by a 05 poll.
- Status model returns 0x01 three times then 0x00 → exactly 4 status bytes read inside one CS-low frame, then proceed.
- POLL_LIMIT=8, status stuck at 0x01 → 8 status bytes read, CS high, error=1, done pulse, bus_req=0.
- length=0 start → done pulse exactly 1 cycle after start; flash_cs_n never low; bus_req never high.
- Assert reset during the third data byte of a frame → next edge: flash_cs_n=1, sck=0, bus_req=0, busy=0. A following start runs a clean transfer.

Source files
------------

// File: rtl/flash_writer.sv
// SPI flash page programmer: masters the RAM bus, reads a block and writes it to flash
// page by page using WREN / Page Program / Read Status polling.
module flash_writer #(
  parameter int RAM_AW     = 19,
  parameter int PAGE_BYTES = 256,
  parameter int POLL_LIMIT = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [RAM_AW-1:0] ram_base,
  input  logic [23:0]       flash_base,
  input  logic [15:0]       length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              bus_req,
  output logic [RAM_AW-1:0] address,
  output logic              rw,
  input  logic [7:0]        data,
  output logic              flash_cs_n,
  output logic              flash_sck,
  output logic              flash_si,
  input  logic              flash_so
);

  localparam int PW  = $clog2(PAGE_BYTES);
  localparam int PCW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_GAP, S_HDR, S_FETCH, S_SHIFT, S_POLL, S_DONE
  } state_t;

  state_t state, state_nxt, gap_tgt, gap_tgt_nxt;

  logic              phase;
  logic [2:0]        bit_cnt;
  logic [1:0]        hdr_idx;
  logic              sub_cnt;
  logic              poll_rd;
  logic [PCW-1:0]    poll_cnt;
  logic [RAM_AW-1:0] ram_ptr;
  logic [23:0]       flash_addr;
  logic [15:0]       remaining;
  logic [7:0]        data_q;
  logic [7:0]        tx_byte;
  logic [23:0]       flash_addr_inc;
  logic              shifting, byte_end, last_byte, poll_timeout;

  assign shifting       = state inside {S_WREN, S_HDR, S_SHIFT, S_POLL};
  assign byte_end       = shifting && phase && (bit_cnt == 3'd7);
  assign flash_addr_inc = flash_addr + 24'd1;
  assign last_byte      = (remaining == 16'd1) || (flash_addr_inc[PW-1:0] == '0);
  assign poll_timeout   = (poll_cnt == PCW'(POLL_LIMIT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      gap_tgt <= S_WREN;
    end else begin
      state   <= state_nxt;
      gap_tgt <= gap_tgt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_tgt_nxt = gap_tgt;
    case (state)
      S_IDLE:  if (start) state_nxt = (length == 16'd0) ? S_DONE : S_WREN;
      S_WREN:  if (byte_end) begin
                 state_nxt   = S_GAP;
                 gap_tgt_nxt = S_HDR;
               end
      S_GAP:   if (sub_cnt) state_nxt = gap_tgt;
      S_HDR:   if (byte_end && hdr_idx == 2'd3) state_nxt = S_FETCH;
      S_FETCH: if (sub_cnt) state_nxt = S_SHIFT;
      S_SHIFT: if (byte_end) begin
                 if (last_byte) begin
                   state_nxt   = S_GAP;
                   gap_tgt_nxt = S_POLL;
                 end else begin
                   state_nxt = S_FETCH;
                 end
               end
      // status bit0 is the last bit on the wire, so flash_so at byte_end is WIP
      S_POLL:  if (byte_end && poll_rd) begin
                 if (!flash_so) begin
                   if (remaining == 16'd0) state_nxt = S_DONE;
                   else begin
                     state_nxt   = S_GAP;
                     gap_tgt_nxt = S_WREN;
                   end
                 end else if (poll_timeout) begin
                   state_nxt = S_DONE;
                 end
               end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state counters restart whenever the state changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase      <= 1'b0;
      bit_cnt    <= 3'd0;
      hdr_idx    <= 2'd0;
      sub_cnt    <= 1'b0;
      poll_rd    <= 1'b0;
      poll_cnt   <= '0;
      ram_ptr    <= '0;
      flash_addr <= 24'd0;
      remaining  <= 16'd0;
      data_q     <= 8'd0;
      error      <= 1'b0;
    end else begin
      if (state != state_nxt) begin
        phase    <= 1'b0;
        bit_cnt  <= 3'd0;
        hdr_idx  <= 2'd0;
        sub_cnt  <= 1'b0;
        poll_rd  <= 1'b0;
        poll_cnt <= '0;
      end else begin
        sub_cnt <= ~sub_cnt;
        if (shifting) begin
          phase <= ~phase;
          if (phase) bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_end) begin
          hdr_idx <= hdr_idx + 2'd1;
          poll_rd <= 1'b1;
          if (poll_rd) poll_cnt <= poll_cnt + PCW'(1);
        end
      end
      if (state == S_IDLE && start) begin
        ram_ptr    <= ram_base;
        flash_addr <= flash_base;
        remaining  <= length;
        error      <= 1'b0;
      end
      if (state == S_FETCH && sub_cnt) data_q <= data;
      if (state == S_SHIFT && byte_end) begin
        ram_ptr    <= ram_ptr + RAM_AW'(1);
        flash_addr <= flash_addr_inc;
        remaining  <= remaining - 16'd1;
      end
      if (state == S_POLL && byte_end && poll_rd && flash_so && poll_timeout) error <= 1'b1;
    end
  end

  always_comb begin
    busy       = !(state inside {S_IDLE, S_DONE});
    bus_req    = busy;
    done       = (state == S_DONE);
    rw         = 1'b1;
    address    = bus_req ? ram_ptr : '0;
    flash_cs_n = !(shifting || state == S_FETCH);
    flash_sck  = shifting && phase;
    tx_byte    = 8'h00;
    case (state)
      S_WREN:  tx_byte = 8'h06;
      S_HDR:   case (hdr_idx)
                 2'd0:    tx_byte = 8'h02;
                 2'd1:    tx_byte = flash_addr[23:16];
                 2'd2:    tx_byte = flash_addr[15:8];
                 default: tx_byte = flash_addr[7:0];
               endcase
      S_SHIFT: tx_byte = data_q;
      S_POLL:  tx_byte = poll_rd ? 8'h00 : 8'h05;
      default: tx_byte = 8'h00;
    endcase
    flash_si = shifting && tx_byte[~bit_cnt];
  end

endmodule

// File: tb/tb_flash_writer.sv
// Bench for flash_writer: RAM model, SPI flash status model and a page-splitting
// reference that predicts every CS frame of a transfer.
module tb_flash_writer;
  localparam int RAM_AW = 19;
  localparam int PAGE   = 256;
  localparam int PLIM   = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [RAM_AW-1:0] ram_base = '0;
  logic [23:0]       flash_base = 24'd0;
  logic [15:0]       length = 16'd0;
  logic              busy, done, error, bus_req, rw;
  logic [RAM_AW-1:0] address;
  logic [7:0]        data = 8'd0;
  logic              flash_cs_n, flash_sck, flash_si;
  logic              flash_so = 1'b0;

  flash_writer #(.RAM_AW(RAM_AW), .PAGE_BYTES(PAGE), .POLL_LIMIT(PLIM)) dut (
    .clock(clock), .reset(reset), .start(start), .ram_base(ram_base),
    .flash_base(flash_base), .length(length), .busy(busy), .done(done),
    .error(error), .bus_req(bus_req), .address(address), .rw(rw), .data(data),
    .flash_cs_n(flash_cs_n), .flash_sck(flash_sck), .flash_si(flash_si),
    .flash_so(flash_so)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM: sparse overrides on top of an address-derived pattern, one cycle read latency
  logic [7:0] mem [int];
  function automatic logic [7:0] mem_rd(input logic [RAM_AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  always @(posedge clock) data <= mem_rd(address);

  // Flash monitor: collects MOSI bytes per CS frame and answers status reads
  logic [7:0] byte_q [$];
  int         len_q [$];
  logic [7:0] exp_bytes [$];
  int         exp_lens [$];
  bit         in_frame = 0;
  int         fbytes = 0, bitcnt = 0, hi_cnt = 100;
  logic [7:0] cur = 8'd0, frame_op = 8'd0;
  logic       sck_prev = 1'b0;
  int         busy_reads = 0, viol = 0, busreq_cycles = 0, done_cnt = 0;

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (bus_req) busreq_cycles++;
    if (bus_req && rw !== 1'b1) viol++;
    if (flash_cs_n) begin
      if (flash_sck) viol++;
      if (in_frame) begin
        if (bitcnt != 0) viol++;
        len_q.push_back(fbytes);
        in_frame = 0;
      end
      hi_cnt++;
    end else begin
      if (!in_frame) begin
        if (hi_cnt < 2) viol++;
        in_frame = 1; fbytes = 0; bitcnt = 0; frame_op = 8'd0;
      end
      hi_cnt = 0;
      if (flash_sck && !sck_prev) begin
        flash_so <= (fbytes >= 1 && frame_op == 8'h05 && bitcnt == 7 && (fbytes - 1) < busy_reads);
        cur = {cur[6:0], flash_si};
        bitcnt++;
        if (bitcnt == 8) begin
          byte_q.push_back(cur);
          if (fbytes == 0) frame_op = cur;
          fbytes++;
          bitcnt = 0;
        end
      end
    end
    sck_prev = flash_sck;
  end

  // Reference: split into page chunks, each WREN / program / poll
  task automatic build_expected(input logic [RAM_AW-1:0] rb, input logic [23:0] fb,
                                input int len, input int br, output bit err);
    int rem, n, cnt;
    logic [23:0] fa;
    logic [RAM_AW-1:0] ra;
    exp_bytes.delete(); exp_lens.delete();
    err = 0; rem = len; fa = fb; ra = rb;
    while (rem > 0 && !err) begin
      exp_bytes.push_back(8'h06); exp_lens.push_back(1);
      n = PAGE - int'(fa % PAGE);
      if (n > rem) n = rem;
      exp_bytes.push_back(8'h02);
      exp_bytes.push_back(fa[23:16]);
      exp_bytes.push_back(fa[15:8]);
      exp_bytes.push_back(fa[7:0]);
      for (int i = 0; i < n; i++) begin
        exp_bytes.push_back(mem_rd(ra));
        ra = ra + RAM_AW'(1);
      end
      exp_lens.push_back(4 + n);
      fa  = fa + 24'(n);
      rem = rem - n;
      if (br >= PLIM) begin cnt = PLIM; err = 1; end
      else cnt = br + 1;
      exp_bytes.push_back(8'h05);
      for (int i = 0; i < cnt; i++) exp_bytes.push_back(8'h00);
      exp_lens.push_back(1 + cnt);
    end
  endtask

  task automatic run_op(input string tag, input logic [RAM_AW-1:0] rb, input logic [23:0] fb,
                        input logic [15:0] len, input int br);
    bit exp_err;
    int cyc, pos, bad;
    build_expected(rb, fb, int'(len), br, exp_err);
    byte_q.delete(); len_q.delete();
    viol = 0; busreq_cycles = 0; done_cnt = 0; busy_reads = br;
    @(negedge clock);
    ram_base = rb; flash_base = fb; length = len; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ram_base = RAM_AW'($urandom); flash_base = 24'($urandom); length = 16'($urandom);
    check({tag, " busy after start"}, busy, (len != 0));
    check({tag, " error cleared"}, error, 1'b0);
    if (len == 0) check({tag, " done next cycle"}, done, 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      start = (cyc == 50);
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    check({tag, " done seen"}, done, 1'b1);
    check({tag, " error"}, error, exp_err);
    check({tag, " bus_req at done"}, bus_req, 1'b0);
    check({tag, " busy at done"}, busy, 1'b0);
    @(negedge clock);
    check({tag, " done one cycle"}, done, 1'b0);
    check({tag, " error sticky"}, error, exp_err);
    repeat (3) @(negedge clock);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " protocol violations"}, viol, 0);
    if (len == 0) check({tag, " no bus"}, busreq_cycles, 0);
    check({tag, " frame count"}, len_q.size(), exp_lens.size());
    if (len_q.size() == exp_lens.size() && byte_q.size() == exp_bytes.size()) begin
      pos = 0;
      for (int f = 0; f < len_q.size(); f++) begin
        check($sformatf("%s frame %0d len", tag, f), len_q[f], exp_lens[f]);
        bad = -1;
        for (int b = 0; b < exp_lens[f] && bad < 0; b++)
          if (byte_q[pos + b] !== exp_bytes[pos + b]) bad = b;
        check($sformatf("%s frame %0d first bad byte", tag, f), bad, -1);
        pos += exp_lens[f];
      end
    end else begin
      check({tag, " byte count"}, byte_q.size(), exp_bytes.size());
    end
  endtask

  initial begin
    int cyc;
    bit reached;
    repeat (3) @(negedge clock);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset error", error, 1'b0);
    check("reset bus_req", bus_req, 1'b0);
    check("reset address", address, '0);
    check("reset rw", rw, 1'b1);
    check("reset cs_n", flash_cs_n, 1'b1);
    check("reset sck", flash_sck, 1'b0);
    check("reset si", flash_si, 1'b0);
    reset = 1'b0;

    mem[32'h01000] = 8'hDE; mem[32'h01001] = 8'hAD;
    mem[32'h01002] = 8'hBE; mem[32'h01003] = 8'hEF;
    run_op("basic",   19'h01000, 24'h000010, 16'd4, 0);
    run_op("cross",   19'h02000, 24'h0000FE, 16'd4, 0);
    run_op("poll3",   19'h03000, 24'h000020, 16'd3, 3);
    run_op("timeout", 19'h04000, 24'h000040, 16'd5, 8);
    run_op("zero",    19'h05000, 24'h000050, 16'd0, 0);
    run_op("wrap",    19'h7FFFE, 24'hFFFFFE, 16'd4, 1);

    // reset in the middle of the third data byte of a program frame
    byte_q.delete(); len_q.delete(); busy_reads = 0;
    @(negedge clock);
    ram_base = 19'h06000; flash_base = 24'h001000; length = 16'd8; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reached = 0; cyc = 0;
    while (!reached && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      reached = in_frame && frame_op == 8'h02 && fbytes == 6 && bitcnt >= 3;
    end
    check("mid reset reached byte 3", reached, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid reset cs_n", flash_cs_n, 1'b1);
    check("mid reset sck", flash_sck, 1'b0);
    check("mid reset bus_req", bus_req, 1'b0);
    check("mid reset busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    run_op("after reset", 19'h06000, 24'h001000, 16'd8, 2);

    for (int k = 0; k < 3; k++) begin
      logic [23:0] fb;
      fb = (k == 0) ? 24'($urandom) : {16'($urandom), 8'($urandom_range(200, 255))};
      run_op($sformatf("rand%0d", k), RAM_AW'($urandom), fb,
             16'($urandom_range(1, 300)), int'($urandom_range(0, 9)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
